// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Recovers pixel timing from an incoming VGA HSYNC/VSYNC pair. Rebuilds the
//   column/row counters, checks line and frame geometry, declares lock after
//   LOCK_FRAMES consecutive clean frames and reports violations once locked.
//
// Ports
//   Clock_25    in   pixel clock, all logic on the rising edge
//   Reset       in   asynchronous active-low reset
//   iHS         in   horizontal sync, active-low
//   iVS         in   vertical sync, active-low, changes on HS falling edges
//   oColumn     out  visible column, 0 when oActive is low
//   oRow        out  visible row, 0 when oActive is low
//   oActive     out  visible pixel while locked
//   oFrameStart out  one-cycle pulse, cycle after each VS falling edge
//   oLocked     out  timing lock
//   oError      out  one-cycle pulse on a timing violation while locked
module vga_sync_receiver #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_VIS       = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_VIS       = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       Clock_25,
  input  logic       Reset,
  input  logic       iHS,
  input  logic       iVS,
  output logic [9:0] oColumn,
  output logic [9:0] oRow,
  output logic       oActive,
  output logic       oFrameStart,
  output logic       oLocked,
  output logic       oError
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_VIS);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Registered state
  logic       hs_prev_q, vs_prev_q;
  logic [9:0] hcnt_q, vcnt_q;
  logic       skip_q;           // next HS fall closes a partial line: do not check it
  logic       line_err_seen_q;  // a line error occurred since the previous VS fall
  state_t     state_q;
  logic [2:0] goodcnt_q;
  logic       locked_q, error_q, frame_start_q;

  // Next-state values
  logic       hs_prev_d, vs_prev_d;
  logic [9:0] hcnt_d, vcnt_d;
  logic       skip_d, line_err_seen_d;
  state_t     state_d;
  logic [2:0] goodcnt_d;
  logic       locked_d, error_d, frame_start_d;

  // Decoded events
  logic hs_fall, vs_fall, timeout, line_err, frame_good;
  logic h_in, v_in;

  // Edge detection, counters and geometry checks
  always_comb begin
    hs_prev_d = iHS;
    vs_prev_d = iVS;
    hs_fall   = hs_prev_q & ~iHS;
    vs_fall   = vs_prev_q & ~iVS;

    // hcnt_q reads 0 in the cycle after the HS fall, so the next fall of a
    // nominal line sees H_TOTAL-1.
    if (hs_fall) begin
      hcnt_d = 10'd0;
    end else if (hcnt_q == CNT_MAX) begin
      hcnt_d = CNT_MAX;
    end else begin
      hcnt_d = hcnt_q + 10'd1;
    end

    // VS fall restarts the frame even though an HS fall arrives with it.
    if (vs_fall) begin
      vcnt_d = 10'd0;
    end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end else begin
      vcnt_d = vcnt_q;
    end

    timeout    = (hcnt_q == CNT_MAX);
    line_err   = hs_fall & ~skip_q & (state_q != ST_SEARCH) & (hcnt_q != H_LAST);
    // A line error in the VS-fall cycle itself also spoils the frame.
    frame_good = (vcnt_q == V_LAST) & ~line_err_seen_q & ~line_err;

    // After a timeout the counter no longer measures a real line.
    if (timeout) begin
      skip_d = 1'b1;
    end else if (hs_fall) begin
      skip_d = 1'b0;
    end else begin
      skip_d = skip_q;
    end

    if (vs_fall) begin
      line_err_seen_d = 1'b0;
    end else if (line_err) begin
      line_err_seen_d = 1'b1;
    end else begin
      line_err_seen_d = line_err_seen_q;
    end
  end

  // Lock FSM next-state logic
  always_comb begin
    state_d   = state_q;
    goodcnt_d = goodcnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d   = ST_MEASURE;
          goodcnt_d = 3'd0;
        end else begin
          state_d   = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (timeout) begin
          state_d   = ST_SEARCH;
          goodcnt_d = 3'd0;
        end else if (vs_fall && frame_good) begin
          if ((goodcnt_q + 3'd1) >= LOCK_N) begin
            state_d   = ST_LOCKED;
            goodcnt_d = LOCK_N;
          end else begin
            goodcnt_d = goodcnt_q + 3'd1;
          end
        end else if (vs_fall) begin
          goodcnt_d = 3'd0;
        end else begin
          goodcnt_d = goodcnt_q;
        end
      end
      ST_LOCKED: begin
        if (timeout) begin
          state_d   = ST_SEARCH;
          goodcnt_d = 3'd0;
        end else if (line_err || (vs_fall && !frame_good)) begin
          state_d   = ST_MEASURE;
          goodcnt_d = 3'd0;
        end else begin
          state_d   = ST_LOCKED;
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        goodcnt_d = 3'd0;
      end
    endcase
  end

  // Lock FSM outputs (registered below)
  always_comb begin
    locked_d      = (state_d == ST_LOCKED);
    frame_start_d = vs_fall;
    if (state_q == ST_LOCKED) begin
      error_d = timeout | line_err | (vs_fall & ~frame_good);
    end else begin
      error_d = 1'b0;
    end
  end

  // State register for edge detectors, counters, checks and FSM
  always_ff @(posedge Clock_25 or negedge Reset) begin
    if (!Reset) begin
      hs_prev_q       <= 1'b1;
      vs_prev_q       <= 1'b1;
      hcnt_q          <= 10'd0;
      vcnt_q          <= 10'd0;
      skip_q          <= 1'b1;
      line_err_seen_q <= 1'b0;
      state_q         <= ST_SEARCH;
      goodcnt_q       <= 3'd0;
      locked_q        <= 1'b0;
      error_q         <= 1'b0;
      frame_start_q   <= 1'b0;
    end else begin
      hs_prev_q       <= hs_prev_d;
      vs_prev_q       <= vs_prev_d;
      hcnt_q          <= hcnt_d;
      vcnt_q          <= vcnt_d;
      skip_q          <= skip_d;
      line_err_seen_q <= line_err_seen_d;
      state_q         <= state_d;
      goodcnt_q       <= goodcnt_d;
      locked_q        <= locked_d;
      error_q         <= error_d;
      frame_start_q   <= frame_start_d;
    end
  end

  // Visible window decode from the registered counters
  always_comb begin
    h_in    = (hcnt_q >= H_START) && (hcnt_q < H_END);
    v_in    = (vcnt_q >= V_START) && (vcnt_q < V_END);
    oActive = locked_q & h_in & v_in;
    if (oActive) begin
      oColumn = hcnt_q - H_START;
      oRow    = vcnt_q - V_START;
    end else begin
      oColumn = 10'd0;
      oRow    = 10'd0;
    end
  end

  assign oLocked     = locked_q;
  assign oError      = error_q;
  assign oFrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver on a reduced geometry
// (20 clocks x 12 lines). The stimulus pushes hand-derived expected events
// (frame start, error, lock/unlock, first/last visible pixel of each line);
// a monitor on the falling clock edge pops and compares them.
module tb_vga_sync_receiver;

  localparam int H_SYNC  = 4;
  localparam int H_BP    = 3;
  localparam int H_VIS   = 8;
  localparam int H_TOTAL = 20;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 3;
  localparam int V_VIS   = 4;
  localparam int V_TOTAL = 12;
  localparam int LONG_LEN = H_SYNC + 1100;

  localparam int EV_FS = 0, EV_ERR = 1, EV_LOCK = 2, EV_UNLOCK = 3, EV_ARISE = 4, EV_AEND = 5;

  typedef struct {
    int kind;
    int t;
    int col;
    int row;
  } ev_t;

  ev_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic [9:0] col, row;
  logic       act, fs, lk, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_locked = 1'b0;
  bit pend_err = 1'b0;

  vga_sync_receiver #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_VIS(H_VIS), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_VIS(V_VIS), .V_TOTAL(V_TOTAL),
    .LOCK_FRAMES(2)
  ) dut (
    .Clock_25(clk), .Reset(rst_n), .iHS(hs), .iVS(vs),
    .oColumn(col), .oRow(row), .oActive(act),
    .oFrameStart(fs), .oLocked(lk), .oError(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_FS:     return "frame_start";
      EV_ERR:    return "error";
      EV_LOCK:   return "lock_rise";
      EV_UNLOCK: return "lock_fall";
      EV_ARISE:  return "first_pixel";
      EV_AEND:   return "last_pixel";
      default:   return "unknown";
    endcase
  endfunction

  function automatic void push(input int k, input int t, input int c, input int r);
    ev_t e;
    e.kind = k; e.t = t; e.col = c; e.row = r;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic got_ev(input int k, input int t, input int c, input int r);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: seen at cycle %0d col %0d row %0d, nothing expected", kname(k), t, c, r);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.t != t || e.col != c || e.row != r) begin
        errors++;
        $display("FAIL %s: got %s cycle %0d col %0d row %0d, expected %s cycle %0d col %0d row %0d",
                 kname(e.kind), kname(k), t, c, r, kname(e.kind), e.t, e.col, e.row);
      end
    end
  endtask

  // Monitor: turn output activity into events and compare against the queue
  bit lk_prev = 1'b0, act_prev = 1'b0;
  int last_t = 0, last_c = 0, last_r = 0;
  always @(negedge clk) begin
    if (fs === 1'b1) got_ev(EV_FS, cyc, 0, 0);
    if (err === 1'b1) got_ev(EV_ERR, cyc, 0, 0);
    if (lk === 1'b1 && !lk_prev) got_ev(EV_LOCK, cyc, 0, 0);
    if (lk !== 1'b1 && lk_prev) got_ev(EV_UNLOCK, cyc, 0, 0);
    if (act === 1'b1 && !act_prev) got_ev(EV_ARISE, cyc, int'(col), int'(row));
    if (act !== 1'b1 && act_prev) got_ev(EV_AEND, last_t, last_c, last_r);
    if (act === 1'b1) begin
      last_t = cyc; last_c = int'(col); last_r = int'(row);
    end else begin
      checks++;
      if (col !== 10'd0 || row !== 10'd0) begin
        errors++;
        $display("FAIL idle_coord: cycle %0d col %0d row %0d, expected 0 0", cyc, col, row);
      end
    end
    lk_prev  = (lk === 1'b1);
    act_prev = (act === 1'b1);
  end

  task automatic rst_assert();
    #2;
    rst_n = 1'b0;
    if (exp_locked) push(EV_UNLOCK, cyc + 1, 0, 0);
    exp_locked = 1'b0;
    pend_err = 1'b0;
    #1;
    check("rst_locked", int'(lk), 0);
    check("rst_active", int'(act), 0);
    check("rst_column", int'(col), 0);
    check("rst_row", int'(row), 0);
  endtask

  task automatic rst_release();
    #2;
    rst_n = 1'b1;
  endtask

  // One frame: nlines lines, line mod_idx gets length mod_len.
  // lock_vs / err_vs: expected lock rise / error at this frame's VS fall.
  task automatic drive_frame(input int nlines, input int mod_idx, input int mod_len,
                             input bit lock_vs, input bit err_vs, input int rst_line);
    int len, c_l, r;
    for (int l = 0; l < nlines; l++) begin
      len = (l == mod_idx) ? mod_len : H_TOTAL;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        hs = (i < H_SYNC) ? 1'b0 : 1'b1;
        vs = (l < V_SYNC) ? 1'b0 : 1'b1;
        if (i == 0) begin
          c_l = cyc;
          if (l == 0) begin
            push(EV_FS, c_l + 1, 0, 0);
            if (err_vs) begin
              push(EV_ERR, c_l + 1, 0, 0);
              push(EV_UNLOCK, c_l + 1, 0, 0);
              exp_locked = 1'b0;
            end
            if (lock_vs) begin
              push(EV_LOCK, c_l + 1, 0, 0);
              exp_locked = 1'b1;
            end
          end
          if (pend_err) begin
            push(EV_ERR, c_l + 1, 0, 0);
            push(EV_UNLOCK, c_l + 1, 0, 0);
            exp_locked = 1'b0;
            pend_err = 1'b0;
          end
          if (exp_locked && l >= V_SYNC + V_BP && l < V_SYNC + V_BP + V_VIS) begin
            r = l - (V_SYNC + V_BP);
            push(EV_ARISE, c_l + 1 + H_SYNC + H_BP, 0, r);
            push(EV_AEND, c_l + H_SYNC + H_BP + H_VIS, H_VIS - 1, r);
          end
          if (l == mod_idx && exp_locked) begin
            if (len < H_TOTAL) begin
              pend_err = 1'b1;
            end else if (len > 1024) begin
              push(EV_ERR, c_l + 1025, 0, 0);
              push(EV_UNLOCK, c_l + 1025, 0, 0);
              exp_locked = 1'b0;
            end
          end
        end
        if (l == rst_line && i == 5) rst_assert();
        if (l == rst_line && i == 15) rst_release();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = 1'b1;
      vs = 1'b1;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_locked", int'(lk), 0);
    check("reset_active", int'(act), 0);
    check("reset_error", int'(err), 0);
    check("reset_frame_start", int'(fs), 0);
    check("reset_column", int'(col), 0);
    check("reset_row", int'(row), 0);
    idle(2);
    rst_release();
    idle(5);

    // Nominal stream: lock at the 3rd VS fall, then two locked frames
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b1, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);

    // Short line (19 clocks) while locked, then relock
    drive_frame(V_TOTAL, 6, H_TOTAL - 1, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b1, 1'b0, -1);

    // Frame one line short while locked: flagged at the following VS fall
    drive_frame(V_TOTAL - 1, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b1, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b1, 1'b0, -1);

    // HS stuck high for 1100 clocks while locked: timeout, back to search
    drive_frame(V_TOTAL, 2, LONG_LEN, 1'b0, 1'b0, -1);
    check("timeout_active", int'(act), 0);
    check("timeout_column", int'(col), 0);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b1, 1'b0, -1);

    // Reset mid-frame while locked, recovery after three VS falls
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, 3);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    drive_frame(V_TOTAL, -1, 0, 1'b1, 1'b0, -1);

    // Reset, then alternating good/bad frame heights: never locks
    idle(3);
    rst_assert();
    idle(10);
    rst_release();
    idle(5);
    for (int f = 0; f < 6; f++) begin
      drive_frame(((f % 2) == 0) ? V_TOTAL : V_TOTAL + 1, -1, 0, 1'b0, 1'b0, -1);
    end
    drive_frame(V_TOTAL, -1, 0, 1'b0, 1'b0, -1);
    idle(10);

    check("alternating_locked", int'(lk), 0);
    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
